seq_mag_cmp: RTL and testbench
==============================

Name: seq_mag_cmp

Overview:
Multi-cycle, parametrised magnitude comparator with a start/done handshake.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle.
- Produces gt/lt/eq flags plus a mode-selected result bit.
- Serves as the sequential successor to the single-bit greater-than cell in fault-simulation benches.
- Latency is fixed and data-independent, so pattern and response timing is deterministic.

Parameters:
WIDTH, 8, operand width in bits; must be ≥ 2.
DIGIT, 1, bits compared per cycle; must divide WIDTH exactly; STEPS = WIDTH/DIGIT.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a comparison; sampled only when not busy.
a  input  WIDTH  operand A; captured on an accepted start.
b  input  WIDTH  operand B; captured on an accepted start.
mode  input  3  result select, captured with the operands: 0 EQ, 1 NE, 2 GT, 3 GE, 4 LT, 5 LE, 6/7 reserved.
busy  output  1  high while a comparison is in progress.
done  output  1  one-cycle pulse; flags and result valid.
gt  output  1  A > B.
lt  output  1  A < B.
eq  output  1  A == B.
result  output  1  flag combination selected by the captured mode.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert use): state IDLE; busy, done, gt, lt, eq and result all 0; internal shift registers and step counter cleared.
- FSM states IDLE, RUN, DONE:
  - IDLE/DONE → RUN when start=1 at an edge. That edge captures a, b and mode, clears the decided/gt/lt tracking, loads the counter with STEPS-1 and sets busy=1.
  - RUN, every edge: compare the top DIGIT bits of the A and B shift registers, then shift both left by DIGIT.
    - If no difference has been decided yet and the digits differ, set the decision: gt if A digit > B digit, else lt.
    - Later digits never override a decision.
    - Decrement the counter.
  - RUN → DONE at the edge where the counter is 0. That edge:
    - drives busy=0 and done=1;
    - latches gt/lt from the decision, and eq = NOT decided;
    - latches result per mode. Reserved modes give result=0.
  - DONE lasts one cycle; done deasserts on the next edge.
  - gt/lt/eq/result hold until the next accepted start. On acceptance they are cleared to 0.
- Latency: if start is accepted at edge k, done is high for the cycle after edge k+STEPS; busy is high from edge k+1 to edge k+STEPS.
- Back-to-back: start=1 while in DONE is accepted at that edge. done still falls, and busy rises on the same edge.
- Start while busy: ignored; operands and mode are not re-captured.
- Exactly one of gt/lt/eq is 1 after any completed comparison.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0. No done pulse for the aborted comparison.
- All comparisons are unsigned unless the optional feature is enabled.

Optional Feature:
- Macro: SEQ_MAG_CMP_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), captured with the operands.
  - When the captured signed_mode=1, the MSB of both captured operands is inverted at capture, giving two's-complement ordering. Latency is unchanged.
- Undefined: port absent; always unsigned.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, mode=2 (GT), start pulsed at edge k → busy high k+1..k+8; done high only after edge k+8; gt=1, lt=0, eq=0, result=1.
- a=b=0xA5, mode=3 (GE) → eq=1, gt=0, lt=0, result=1. Then mode=1 (NE) with the same operands → result=0.
- Start at edge k with a=0x01, b=0x02, mode=4 (LT). At k+3, assert start with a=0xFF, b=0x00 → second start ignored; done at k+8 with lt=1, result=1.
- Reset pulsed low at edge k+4 of a running comparison → busy, done, flags and result all 0 immediately; no done pulse follows; a new start then completes normally in 8 cycles.
- SEQ_MAG_CMP_SIGNED_EN defined: a=0x80, b=0x01, mode=2 → signed_mode=0 gives gt=1, result=1; signed_mode=1 gives lt=1, result=0.
- WIDTH=16, DIGIT=4: a=0x1234, b=0x1235, mode=5 (LE), with start also asserted in the DONE cycle of the previous run → busy 4 cycles, done after edge k+4, lt=1, result=1; the back-to-back start is accepted.

Source files
------------

// File: rtl/seq_mag_cmp.sv
// Multi-cycle MSB-first magnitude comparator with start/done handshake.
// Optional signed ordering enabled by defining SEQ_MAG_CMP_SIGNED_EN.
module seq_mag_cmp #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
`ifdef SEQ_MAG_CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             result
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           stateQ, stateD;
  logic [WIDTH-1:0] aSh, bSh;
  logic [WIDTH-1:0] aCap, bCap;
  logic [2:0]       modeQ;
  logic [CW-1:0]    cnt;
  logic             decided, gtD, ltD;

  logic             accept, lastStep;
  logic [DIGIT-1:0] aDig, bDig;
  logic             digDiff, newDecided, newGt, newLt, modeRes;

  assign accept   = start && (stateQ != RUN);
  assign lastStep = (stateQ == RUN) && (cnt == '0);
  assign busy     = (stateQ == RUN);
  assign done     = (stateQ == DONE);

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (start) stateD = RUN;
      RUN:     if (cnt == '0) stateD = DONE;
      DONE:    stateD = start ? RUN : IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  always_comb begin
    aCap = a;
    bCap = b;
`ifdef SEQ_MAG_CMP_SIGNED_EN
    if (signed_mode) begin
      aCap[WIDTH-1] = ~a[WIDTH-1];
      bCap[WIDTH-1] = ~b[WIDTH-1];
    end
`endif
  end

  // The decision including the digit compared this cycle, so the final
  // step's digit is visible when the flags are latched.
  always_comb begin
    aDig       = aSh[WIDTH-1 -: DIGIT];
    bDig       = bSh[WIDTH-1 -: DIGIT];
    digDiff    = (aDig != bDig);
    newDecided = decided | digDiff;
    newGt      = decided ? gtD : (digDiff && (aDig > bDig));
    newLt      = decided ? ltD : (digDiff && (aDig < bDig));
    case (modeQ)
      3'd0:    modeRes = !newDecided;
      3'd1:    modeRes = newDecided;
      3'd2:    modeRes = newGt;
      3'd3:    modeRes = newGt | !newDecided;
      3'd4:    modeRes = newLt;
      3'd5:    modeRes = newLt | !newDecided;
      default: modeRes = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aSh     <= '0;
      bSh     <= '0;
      modeQ   <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gtD     <= 1'b0;
      ltD     <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      result  <= 1'b0;
    end else if (accept) begin
      aSh     <= aCap;
      bSh     <= bCap;
      modeQ   <= mode;
      cnt     <= CW'(STEPS - 1);
      decided <= 1'b0;
      gtD     <= 1'b0;
      ltD     <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      result  <= 1'b0;
    end else if (stateQ == RUN) begin
      aSh     <= aSh << DIGIT;
      bSh     <= bSh << DIGIT;
      cnt     <= cnt - 1'b1;
      decided <= newDecided;
      gtD     <= newGt;
      ltD     <= newLt;
      if (lastStep) begin
        gt     <= newGt;
        lt     <= newLt;
        eq     <= !newDecided;
        result <= modeRes;
      end
    end
  end

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Directed self-checking bench for seq_mag_cmp (8x1 and 16x4 instances).
module tb_seq_mag_cmp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, signed8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  mode8 = '0;
  logic        busy8, done8, gt8, lt8, eq8, res8;

  logic        start16 = 1'b0, signed16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [2:0]  mode16 = '0;
  logic        busy16, done16, gt16, lt16, eq16, res16;

  int checks = 0;
  int errors = 0;

  seq_mag_cmp #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .mode(mode8),
`ifdef SEQ_MAG_CMP_SIGNED_EN
    .signed_mode(signed8),
`endif
    .busy(busy8), .done(done8), .gt(gt8), .lt(lt8), .eq(eq8), .result(res8)
  );

  seq_mag_cmp #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .mode(mode16),
`ifdef SEQ_MAG_CMP_SIGNED_EN
    .signed_mode(signed16),
`endif
    .busy(busy16), .done(done16), .gt(gt16), .lt(lt16), .eq(eq16), .result(res16)
  );

  // Drive a one-cycle start on the 8-bit instance; returns after the accepting edge.
  task automatic pulse8(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] tm,
                        input logic ts);
    a8 = ta; b8 = tb; mode8 = tm; signed8 = ts; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy8, done8, gt8, lt8, eq8, res8} !== 6'b0) begin
      errors++;
      $display("FAIL reset8: got %b expected 000000", {busy8, done8, gt8, lt8, eq8, res8});
    end
    checks++;
    if ({busy16, done16, gt16, lt16, eq16, res16} !== 6'b0) begin
      errors++;
      $display("FAIL reset16: got %b expected 000000", {busy16, done16, gt16, lt16, eq16, res16});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gt_latency;
    pulse8(8'h5A, 8'h3C, 3'd2, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if ({busy8, done8} !== 2'b10) begin
        errors++;
        $display("FAIL gt_busy cycle %0d: busy,done=%b expected 10", i, {busy8, done8});
      end
      @(negedge clk);
    end
    checks++;
    if ({busy8, done8, gt8, lt8, eq8, res8} !== 6'b011001) begin
      errors++;
      $display("FAIL gt_done: busy,done,gt,lt,eq,res=%b expected 011001",
               {busy8, done8, gt8, lt8, eq8, res8});
    end
    @(negedge clk);
    checks++;
    if ({busy8, done8, gt8, lt8, eq8, res8} !== 6'b001001) begin
      errors++;
      $display("FAIL gt_hold: busy,done,gt,lt,eq,res=%b expected 001001",
               {busy8, done8, gt8, lt8, eq8, res8});
    end
  endtask

  task automatic test_eq_modes;
    logic ok;
    pulse8(8'hA5, 8'hA5, 3'd3, 1'b0);
    checks++;
    if ({gt8, lt8, eq8, res8} !== 4'b0000) begin
      errors++;
      $display("FAIL eq_cleared: gt,lt,eq,res=%b expected 0000", {gt8, lt8, eq8, res8});
    end
    wait_done8(ok);
    checks++;
    if (!ok || {gt8, lt8, eq8, res8} !== 4'b0011) begin
      errors++;
      $display("FAIL eq_ge: done=%b gt,lt,eq,res=%b expected done=1 0011", ok, {gt8, lt8, eq8, res8});
    end
    @(negedge clk);
    pulse8(8'hA5, 8'hA5, 3'd1, 1'b0);
    wait_done8(ok);
    checks++;
    if (!ok || {gt8, lt8, eq8, res8} !== 4'b0010) begin
      errors++;
      $display("FAIL eq_ne: done=%b gt,lt,eq,res=%b expected done=1 0010", ok, {gt8, lt8, eq8, res8});
    end
    @(negedge clk);
    pulse8(8'h5A, 8'h3C, 3'd6, 1'b0);
    wait_done8(ok);
    checks++;
    if (!ok || {gt8, lt8, eq8, res8} !== 4'b1000) begin
      errors++;
      $display("FAIL reserved_mode: done=%b gt,lt,eq,res=%b expected done=1 1000", ok, {gt8, lt8, eq8, res8});
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    pulse8(8'h01, 8'h02, 3'd4, 1'b0);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; mode8 = 3'd2; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 3; i <= 8; i++) begin
      checks++;
      if (done8 !== 1'b0) begin
        errors++;
        $display("FAIL busy_ignore_early cycle %0d: done=%b expected 0", i, done8);
      end
      @(negedge clk);
    end
    checks++;
    if ({busy8, done8, gt8, lt8, eq8, res8} !== 6'b010101) begin
      errors++;
      $display("FAIL busy_ignore_done: busy,done,gt,lt,eq,res=%b expected 010101",
               {busy8, done8, gt8, lt8, eq8, res8});
    end
    @(negedge clk);
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      errors++;
      $display("FAIL busy_ignore_idle: busy,done=%b expected 00", {busy8, done8});
    end
  endtask

  task automatic test_reset_mid_run;
    logic seenDone = 1'b0;
    pulse8(8'h5A, 8'h3C, 3'd2, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, gt8, lt8, eq8, res8} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid: got %b expected 000000", {busy8, done8, gt8, lt8, eq8, res8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) seenDone = 1'b1;
    end
    checks++;
    if (seenDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: activity=%b expected 0", seenDone);
    end
    pulse8(8'h10, 8'h20, 3'd5, 1'b0);
    repeat (7) @(negedge clk);
    checks++;
    if ({busy8, done8} !== 2'b10) begin
      errors++;
      $display("FAIL reset_restart_busy: busy,done=%b expected 10", {busy8, done8});
    end
    @(negedge clk);
    checks++;
    if ({busy8, done8, gt8, lt8, eq8, res8} !== 6'b010101) begin
      errors++;
      $display("FAIL reset_restart_done: got %b expected 010101", {busy8, done8, gt8, lt8, eq8, res8});
    end
    @(negedge clk);
  endtask

`ifdef SEQ_MAG_CMP_SIGNED_EN
  task automatic test_signed;
    logic ok;
    pulse8(8'h80, 8'h01, 3'd2, 1'b0);
    wait_done8(ok);
    checks++;
    if (!ok || {gt8, lt8, eq8, res8} !== 4'b1001) begin
      errors++;
      $display("FAIL signed_off: done=%b gt,lt,eq,res=%b expected done=1 1001", ok, {gt8, lt8, eq8, res8});
    end
    @(negedge clk);
    pulse8(8'h80, 8'h01, 3'd2, 1'b1);
    wait_done8(ok);
    checks++;
    if (!ok || {gt8, lt8, eq8, res8} !== 4'b0100) begin
      errors++;
      $display("FAIL signed_on: done=%b gt,lt,eq,res=%b expected done=1 0100", ok, {gt8, lt8, eq8, res8});
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back;
    a16 = 16'h0000; b16 = 16'h0000; mode16 = 3'd0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy16, done16} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_first_busy: busy,done=%b expected 10", {busy16, done16});
    end
    @(negedge clk);
    checks++;
    if ({busy16, done16, gt16, lt16, eq16, res16} !== 6'b010011) begin
      errors++;
      $display("FAIL b2b_first_done: got %b expected 010011", {busy16, done16, gt16, lt16, eq16, res16});
    end
    a16 = 16'h1234; b16 = 16'h1235; mode16 = 3'd5; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    checks++;
    if ({busy16, done16, gt16, lt16, eq16, res16} !== 6'b100000) begin
      errors++;
      $display("FAIL b2b_accept: got %b expected 100000", {busy16, done16, gt16, lt16, eq16, res16});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy16, done16} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_second_busy: busy,done=%b expected 10", {busy16, done16});
    end
    @(negedge clk);
    checks++;
    if ({busy16, done16, gt16, lt16, eq16, res16} !== 6'b010101) begin
      errors++;
      $display("FAIL b2b_second_done: got %b expected 010101", {busy16, done16, gt16, lt16, eq16, res16});
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_gt_latency();
    test_eq_modes();
    test_start_while_busy();
    test_reset_mid_run();
`ifdef SEQ_MAG_CMP_SIGNED_EN
    test_signed();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
